mem_access_unit: RTL
====================

# mem_access_unit

Load/store unit sitting between the execute stage and the data-memory subsystem (cache plus main memory). It latches one access per instruction, splits misaligned halfword/word accesses into two aligned word beats with byte enables, and drives a ready/valid request to memory. It returns the sign- or zero-extended load result and holds the upstream pipeline with `stall_o` until the access completes.

## Interface
- `DATA_WIDTH`, 32, data and address width; byte lanes = `DATA_WIDTH/8`, fixed at 4.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  execute presents a load/store this cycle.
- `write_en_i`  in  1  1 = store, 0 = load.
- `mem_type_i`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `mem_sign_i`  in  1  1 = sign-extend load, 0 = zero-extend.
- `addr_i`  in  32  byte address (ALU result).
- `write_data_i`  in  32  store data, right-aligned.
- `stall_o`  out  1  hold PC and pipeline registers upstream.
- `read_data_o`  out  32  extended load result; valid when `rdata_valid_o`.
- `rdata_valid_o`  out  1  one-cycle completion pulse (loads and stores).
- `misalign_o`  out  1  one-cycle pulse at completion if the access took two beats.
- `mem_req_o`  out  1  memory request valid.
- `mem_we_o`  out  1  memory write.
- `mem_addr_o`  out  32  word-aligned address, bits [1:0] = 0.
- `mem_be_o`  out  4  byte-lane enables.
- `mem_wdata_o`  out  32  lane-positioned write data.
- `mem_rdata_i`  in  32  read word, valid in the cycle `mem_ready_i` = 1.
- `mem_ready_i`  in  1  memory accepts the current beat.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE: on `req_valid_i`, latch we, type, sign, addr and data → BEAT0. `off = addr[1:0]`, `size` = 1/2/4, `split = off+size > 4`.
- BEAT0: `mem_addr_o = {addr[31:2],2'b00}`, `mem_be_o = mask(size) << off` truncated to 4 bits. On `mem_ready_i`: store the read lanes enabled this beat into the lane buffer → BEAT1 if split, else DONE.
- BEAT1: `mem_addr_o` = BEAT0 address + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000. `mem_be_o = mask(size) >> (4-off)`. On `mem_ready_i`: capture the read lanes → DONE.
- `mem_wdata_o` = `write_data` rotated left by `8*off` in both beats.
- `mem_req_o` = 1 in BEAT0/BEAT1. It holds stable (addr, be, wdata, we) until `mem_ready_i`.
- DONE: pulse `rdata_valid_o`. `read_data_o` = lane buffer rotated right by `8*off`, then byte/half extended per `mem_sign_i`. Stores drive `read_data_o` = 0. Unconditional → IDLE.
- `stall_o` = (IDLE & `req_valid_i`) | BEAT0 | BEAT1. It is low in DONE, so the pipeline advances at the end of DONE. A request seen in DONE is the same instruction and is ignored.
- Memory wait states (`mem_ready_i` = 0) hold the current state indefinitely. There is no timeout.

## Timing
- Reset values: state IDLE, all outputs 0, lane buffer 0. Reset asserted mid-access drops `mem_req_o` immediately. A completed BEAT0 store is not rolled back.
- Aligned access with `mem_ready_i` tied 1: accepted in cycle 0 (IDLE), beat in cycle 1, DONE in cycle 2. `stall_o` is high for cycles 0–1.
- Split access: one extra cycle, so `stall_o` is high for 3 cycles minimum.
- Each wait cycle on a beat adds exactly one stall cycle.
- `read_data_o` and `rdata_valid_o` are registered-state outputs, valid only in DONE.

## Structure
- `mem_access_pkg`: `mem_type_t` enum (BYTE, HALF, WORD), `lsu_state_t` enum, and a `size_mask(mem_type_t)` function returning 4'b0001/0011/1111.
- Sub-module `lsu_align`: combinational rotate-left for write data, rotate-right plus sign/zero extension for load data. It is shared by both directions and unit-testable on its own.

## Test plan
- Aligned word load, addr 0x100, `mem_rdata_i` 0xDEADBEEF, ready=1 → one beat with be 1111, `read_data_o` 0xDEADBEEF, `stall_o` high 2 cycles, `misalign_o` 0.
- Signed byte load, addr 0x103, rdata 0x80xxxxxx → be 1000, `read_data_o` 0xFFFFFF80. Repeat with `mem_sign_i` = 0 → 0x00000080.
- Misaligned word store 0x11223344 at 0x102 → beat 0: addr 0x100, be 1100, wdata 0x33441122. Beat 1: addr 0x104, be 0011, wdata 0x33441122. `misalign_o` pulses.
- Misaligned half load at 0xFFFFFFFF, beat 0 rdata 0xAB000000, beat 1 rdata 0x000000CD, unsigned → second beat addr 0x00000000, `read_data_o` 0x0000CDAB.
- Random `mem_ready_i` low for 3 cycles on each beat → request fields held stable, `stall_o` extended by exactly 6 cycles, result unchanged.
- Assert `rst` during BEAT1 → `mem_req_o`, `stall_o` and `rdata_valid_o` are 0 in the same cycle. After release, state is IDLE and the next request completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared types and helpers for the load/store unit.
//   mem_type_t   - access width (BYTE, HALF, WORD); raw code 2'b11 decodes to WORD
//   lsu_state_t  - load/store sequencer states
//   size_mask()  - contiguous byte-lane mask for an access width, lane 0 based
//   size_bytes() - access width in bytes
//   decode_type()- raw 2-bit type code to mem_type_t
package mem_access_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    DONE  = 2'b11
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input mem_type_t t);
    case (t)
      BYTE:    return 4'b0001;
      HALF:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input mem_type_t t);
    case (t)
      BYTE:    return 3'd1;
      HALF:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic mem_type_t decode_type(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// lsu_align: combinational lane alignment shared by stores and loads.
//   wdata_i  - right-aligned store data
//   off_i    - byte offset of the access within its word
//   lanes_i  - assembled read lanes (memory lane positions)
//   type_i   - raw access type code (2'b11 behaves as word)
//   sign_i   - 1 sign-extends byte/half loads, 0 zero-extends
//   wdata_o  - store data rotated left by 8*off into lane position
//   rdata_o  - read lanes rotated right by 8*off, then extended
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] lanes_i,
  input  logic [1:0]  type_i,
  input  logic        sign_i,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] aligned;
  mem_type_t   mtype;

  assign mtype = decode_type(type_i);

  always_comb begin
    case (off_i)
      2'd0:    wdata_o = wdata_i;
      2'd1:    wdata_o = {wdata_i[23:0], wdata_i[31:24]};
      2'd2:    wdata_o = {wdata_i[15:0], wdata_i[31:16]};
      default: wdata_o = {wdata_i[7:0],  wdata_i[31:8]};
    endcase
  end

  always_comb begin
    case (off_i)
      2'd0:    aligned = lanes_i;
      2'd1:    aligned = {lanes_i[7:0],  lanes_i[31:8]};
      2'd2:    aligned = {lanes_i[15:0], lanes_i[31:16]};
      default: aligned = {lanes_i[23:0], lanes_i[31:24]};
    endcase
  end

  always_comb begin
    case (mtype)
      BYTE:    rdata_o = {{24{sign_i & aligned[7]}},  aligned[7:0]};
      HALF:    rdata_o = {{16{sign_i & aligned[15]}}, aligned[15:0]};
      default: rdata_o = aligned;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between execute and data memory.
// Latches one access per instruction, splits accesses that cross a word
// boundary into two aligned word beats, and holds the pipeline until done.
//   clk, rst        - clock, asynchronous active-high reset
//   req_valid_i     - execute presents a load/store
//   write_en_i      - 1 store, 0 load
//   mem_type_i      - 00 byte, 01 half, 10/11 word
//   mem_sign_i      - sign-extend loads when 1
//   addr_i          - byte address
//   write_data_i    - right-aligned store data
//   stall_o         - hold upstream pipeline
//   read_data_o     - extended load result (valid with rdata_valid_o)
//   rdata_valid_o   - one-cycle completion pulse
//   misalign_o      - completion pulse for two-beat accesses
//   mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o - memory request
//   mem_rdata_i/mem_ready_i - memory response
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  input  logic                  write_en_i,
  input  logic [1:0]            mem_type_i,
  input  logic                  mem_sign_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  rdata_valid_o,
  output logic                  misalign_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i
);

  lsu_state_t  state_q;
  logic        we_q;
  mem_type_t   type_q;
  logic        sign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        split_q;
  logic [31:0] lane_q;
  logic [31:0] lane_d;

  logic [2:0]  span_d;
  logic        split_d;
  logic [7:0]  lane_mask_wide;
  logic [3:0]  be_cur;
  logic [31:0] word_addr;
  logic [31:0] addr_cur;
  logic [31:0] wdata_rot;
  logic [31:0] rdata_ext;
  logic        in_beat;

  // Offset plus size tops out at 3+4=7, so three bits cannot overflow.
  assign span_d  = {1'b0, addr_i[1:0]} + size_bytes(decode_type(mem_type_i));
  assign split_d = (span_d > 3'd4);

  // The size mask shifted into an 8-lane window: the low nibble is the first
  // word's lanes, the high nibble is what spills into the next word.
  assign lane_mask_wide = {4'b0000, size_mask(type_q)} << addr_q[1:0];

  assign word_addr = {addr_q[31:2], 2'b00};
  assign in_beat   = (state_q == BEAT0) || (state_q == BEAT1);

  always_comb begin
    be_cur   = 4'b0000;
    addr_cur = word_addr;
    case (state_q)
      BEAT0: be_cur = lane_mask_wide[3:0];
      BEAT1: begin
        be_cur   = lane_mask_wide[7:4];
        addr_cur = word_addr + 32'd4;   // wraps past 0xFFFFFFFC to 0
      end
      default: ;
    endcase
  end

  // Merge only the lanes this beat owns so the other beat's bytes survive.
  always_comb begin
    lane_d = lane_q;
    for (int i = 0; i < 4; i++) begin
      if (be_cur[i]) lane_d[8*i +: 8] = mem_rdata_i[8*i +: 8];
    end
  end

  lsu_align u_align (
    .wdata_i (wdata_q),
    .off_i   (addr_q[1:0]),
    .lanes_i (lane_q),
    .type_i  (type_q),
    .sign_i  (sign_q),
    .wdata_o (wdata_rot),
    .rdata_o (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= BYTE;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      split_q <= 1'b0;
      lane_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= write_en_i;
            type_q  <= decode_type(mem_type_i);
            sign_q  <= mem_sign_i;
            addr_q  <= addr_i;
            wdata_q <= write_data_i;
            split_q <= split_d;
            state_q <= BEAT0;
          end
        end
        BEAT0: begin
          if (mem_ready_i) begin
            lane_q  <= lane_d;
            state_q <= split_q ? BEAT1 : DONE;
          end
        end
        BEAT1: begin
          if (mem_ready_i) begin
            lane_q  <= lane_d;
            state_q <= DONE;
          end
        end
        // DONE: the request still visible here is the completed instruction.
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = in_beat;
  assign mem_we_o    = in_beat & we_q;
  assign mem_addr_o  = in_beat ? addr_cur : '0;
  assign mem_be_o    = be_cur;
  assign mem_wdata_o = (in_beat & we_q) ? wdata_rot : '0;

  // Gated by rst so the pipeline is released the moment reset hits.
  assign stall_o = ~rst & (((state_q == IDLE) & req_valid_i) | in_beat);

  assign rdata_valid_o = (state_q == DONE);
  assign misalign_o    = (state_q == DONE) & split_q;
  assign read_data_o   = ((state_q == DONE) & ~we_q) ? rdata_ext : '0;

endmodule
